banked_mem_arb: RTL and testbench

- Parametrised multi-bank SRAM: BANKS banks × SUBBANKS sub-banks × WORDS words of DATA_W bits.
- Successor to the fixed 4×4×128×8 banked memory. Adds:
  - concurrent read and write to different sub-banks;
  - a one-entry deferred-write buffer for same-sub-bank conflicts, with read forwarding from it;
  - write backpressure, a registered read-valid, and a sticky drop flag.
- Serves as the scratch/buffer memory for the lab datapaths.

---
 rtl/banked_mem_arb.sv | 121 ++++++++++++
 tb/tb_banked_mem_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/banked_mem_arb.sv
// rtl/banked_mem_arb.sv - banked SRAM with one-entry deferred-write buffer and read forwarding
module banked_mem_arb #(
  parameter int DATA_W   = 8,
  parameter int BANKS    = 4,
  parameter int SUBBANKS = 4,
  parameter int WORDS    = 128,
  localparam int BANK_W  = $clog2(BANKS),
  localparam int SUB_W   = $clog2(SUBBANKS),
  localparam int WORD_W  = $clog2(WORDS),
  localparam int ADDR_W  = BANK_W + SUB_W + WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  output logic              wready,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              wdrop
);

  localparam int SB_ID_W = BANK_W + SUB_W;
  localparam int DEPTH   = BANKS * SUBBANKS * WORDS;

  // Flat storage; the {bank, sub-bank, word} split maps directly onto the address bits.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rvalid_q, rvalid_d;
  logic              wdrop_q, wdrop_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  logic [SB_ID_W-1:0] sb_r, sb_w, sb_p;
  logic               w_acc, w_conf, drain;

  assign sb_r = raddr[ADDR_W-1:WORD_W];
  assign sb_w = waddr[ADDR_W-1:WORD_W];
  assign sb_p = pend_addr_q[ADDR_W-1:WORD_W];

  // A new write is only accepted with the buffer empty; a read always wins its sub-bank.
  assign w_acc  = wen & ~pend_v_q;
  assign w_conf = w_acc & ren & (sb_w == sb_r);
  assign drain  = pend_v_q & (~ren | (sb_p != sb_r));

  // Next-state for pending buffer, read pipeline, drop flag and the single array write port.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wdrop_d     = wdrop_q | (wen & pend_v_q);
    mem_we      = 1'b0;
    mem_waddr   = waddr;
    mem_wdata   = din;
    dout_d      = '0;
    rvalid_d    = ren;

    // drain and a fresh accepted write are mutually exclusive (pend_v gates both)
    if (drain) begin
      mem_we    = 1'b1;
      mem_waddr = pend_addr_q;
      mem_wdata = pend_data_q;
      pend_v_d  = 1'b0;
    end else if (w_conf) begin
      pend_v_d    = 1'b1;
      pend_addr_d = waddr;
      pend_data_d = din;
    end else if (w_acc) begin
      mem_we = 1'b1;
    end

    // Pending data is newer than the array, so it shadows the array on an exact address hit.
    if (ren) begin
      if (pend_v_q && (raddr == pend_addr_q)) begin
        dout_d = pend_data_q;
      end else begin
        dout_d = mem[raddr];
      end
    end
  end

  // Control and output registers; reset discards any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      dout_q      <= '0;
      rvalid_q    <= 1'b0;
      wdrop_q     <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      dout_q      <= dout_d;
      rvalid_q    <= rvalid_d;
      wdrop_q     <= wdrop_d;
    end
  end

  // Array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign wready = ~pend_v_q;
  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign wdrop  = wdrop_q;

endmodule

// File: tb/tb_banked_mem_arb.sv
// tb/tb_banked_mem_arb.sv - directed self-checking bench for banked_mem_arb
module tb_banked_mem_arb;

  logic        clk;
  logic        rst_n;

  // default-parameter instance
  logic        ren, wen;
  logic [10:0] raddr, waddr;
  logic [7:0]  din;
  logic        wready, rvalid, wdrop;
  logic [7:0]  dout;

  // swept-parameter instance
  logic        b_ren, b_wen;
  logic [8:0]  b_raddr, b_waddr;
  logic [15:0] b_din;
  logic        b_wready, b_rvalid, b_wdrop;
  logic [15:0] b_dout;

  int n_checks = 0;
  int n_pass   = 0;

  banked_mem_arb u_dut (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .raddr(raddr),
    .wen(wen), .waddr(waddr), .din(din),
    .wready(wready), .dout(dout), .rvalid(rvalid), .wdrop(wdrop)
  );

  banked_mem_arb #(.DATA_W(16), .BANKS(2), .SUBBANKS(8), .WORDS(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .ren(b_ren), .raddr(b_raddr),
    .wen(b_wen), .waddr(b_waddr), .din(b_din),
    .wready(b_wready), .dout(b_dout), .rvalid(b_rvalid), .wdrop(b_wdrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // advance one edge and settle just past it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren = 0; wen = 0; b_ren = 0; b_wen = 0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    idle(); wen = 1; waddr = a; din = d; cyc(); idle();
  endtask

  task automatic rd(input logic [10:0] a);
    idle(); ren = 1; raddr = a; cyc(); idle();
  endtask

  task automatic b_wr(input logic [8:0] a, input logic [15:0] d);
    idle(); b_wen = 1; b_waddr = a; b_din = d; cyc(); idle();
  endtask

  task automatic b_rd(input logic [8:0] a);
    idle(); b_ren = 1; b_raddr = a; cyc(); idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    raddr = '0; waddr = '0; din = '0;
    b_raddr = '0; b_waddr = '0; b_din = '0;
    #12;
    check("rst_dout", dout, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_wdrop", wdrop, 0);
    check("rst_wready", wready, 1);
    rst_n = 1;
    cyc();

    // 1: basic write then read, then idle clears output
    wr(11'h000, 8'hA5);
    rd(11'h000);
    check("t1_dout", dout, 8'hA5);
    check("t1_rvalid", rvalid, 1);
    cyc();
    check("t1_idle_dout", dout, 0);
    check("t1_idle_rvalid", rvalid, 0);

    // 2: concurrent read and write to different sub-banks
    wr(11'h7FF, 8'h11);
    ren = 1; raddr = 11'h7FF; wen = 1; waddr = 11'h100; din = 8'h3C;
    cyc(); idle();
    check("t2_dout", dout, 8'h11);
    check("t2_wready", wready, 1);
    rd(11'h100);
    check("t2_rd100", dout, 8'h3C);

    // 3: same-sub-bank conflict, forwarding, drain
    wr(11'h005, 8'h22);
    wr(11'h006, 8'h00);
    ren = 1; raddr = 11'h005; wen = 1; waddr = 11'h006; din = 8'h77;
    cyc(); idle();
    check("t3_dout", dout, 8'h22);
    check("t3_wready0", wready, 0);
    rd(11'h006);
    check("t3_fwd", dout, 8'h77);
    check("t3_held", wready, 0);
    cyc();
    check("t3_drained", wready, 1);
    rd(11'h006);
    check("t3_rd006", dout, 8'h77);

    // 4: write while buffer full is dropped and sticky
    wr(11'h200, 8'h44);
    ren = 1; raddr = 11'h005; wen = 1; waddr = 11'h007; din = 8'h12;
    cyc(); idle();
    check("t4_wready0", wready, 0);
    ren = 1; raddr = 11'h005; wen = 1; waddr = 11'h200; din = 8'h99;
    cyc(); idle();
    check("t4_wdrop", wdrop, 1);
    cyc(); cyc();
    check("t4_wdrop_sticky", wdrop, 1);
    check("t4_wready1", wready, 1);
    rd(11'h200);
    check("t4_rd200", dout, 8'h44);
    rd(11'h007);
    check("t4_rd007", dout, 8'h12);

    // 5: reset with pending write discards it
    wr(11'h010, 8'h66);
    ren = 1; raddr = 11'h011; wen = 1; waddr = 11'h010; din = 8'h55;
    cyc();
    wen = 0;
    check("t5_pend", wready, 0);
    check("t5_rvalid1", rvalid, 1);
    #2 rst_n = 0;
    #1;
    check("t5_rvalid0", rvalid, 0);
    check("t5_wready1", wready, 1);
    check("t5_wdrop0", wdrop, 0);
    idle();
    cyc();
    rst_n = 1;
    cyc();
    rd(11'h010);
    check("t5_rd010", dout, 8'h66);

    // 6: swept parameters (ADDR_W=9, DATA_W=16)
    b_wr(9'h1FF, 16'hBEEF);
    b_rd(9'h1FF);
    check("t6_beef", b_dout, 16'hBEEF);
    check("t6_rvalid", b_rvalid, 1);
    b_wr(9'h005, 16'h2222);
    b_wr(9'h006, 16'h0000);
    b_ren = 1; b_raddr = 9'h005; b_wen = 1; b_waddr = 9'h006; b_din = 16'h7777;
    cyc(); idle();
    check("t6_dout", b_dout, 16'h2222);
    check("t6_wready0", b_wready, 0);
    b_rd(9'h006);
    check("t6_fwd", b_dout, 16'h7777);
    check("t6_held", b_wready, 0);
    cyc();
    check("t6_drained", b_wready, 1);
    b_rd(9'h006);
    check("t6_rd006", b_dout, 16'h7777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
